// File: rtl/obj_line_scheduler.sv
// rtl/obj_line_scheduler.sv - per-scanline object scheduler for one renderer quadrant
//
// Purpose: during horizontal blanking, scan the object table one entry per
// cycle, keep the entries that cover the next scanline in this quadrant, and
// sort them nearest-first ({r, idx} ascending) into a shadow slot table. The
// shadow table is published to the active table on line_commit.
//
// Optional feature: define OBJ_SCHED_STATS_EN to add frame_start/drop_count.
//
// Ports:
//   clk           pixel-domain clock
//   rst           asynchronous reset, active-low
//   line_start    pulse; start a scan for line_y (restarts a running scan)
//   line_y        scanline to schedule, 0..479
//   line_commit   pulse at start of active video; publishes the shadow table
//   obj_idx       object table read index (table answers in the same cycle)
//   obj_active    entry active
//   obj_quadrant  entry quadrant
//   obj_r         entry distance, 0 = nearest
//   obj_y_pos     entry top row
//   slot_valid    active-table slot occupied, slot 0 = highest priority
//   slot_idx      active-table object index, slot k at [k*IDX_W +: IDX_W]
//   busy          scan in progress
//   overflow      more than SLOTS candidates on the last committed line
//   late_err      sticky: scan aborted, or commit arrived before scan finished
//   frame_start   (OBJ_SCHED_STATS_EN) clears drop_count
//   drop_count    (OBJ_SCHED_STATS_EN) saturating count of dropped/evicted candidates

module obj_line_scheduler #(
  parameter int OBJ_LIMIT = 16,
  parameter int SLOTS     = 4,
  parameter int QUADRANT  = 0,
  parameter int IDX_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line_start,
  input  logic [9:0]             line_y,
  input  logic                   line_commit,
  output logic [IDX_W-1:0]       obj_idx,
  input  logic                   obj_active,
  input  logic [1:0]             obj_quadrant,
  input  logic [3:0]             obj_r,
  input  logic [9:0]             obj_y_pos,
  output logic [SLOTS-1:0]       slot_valid,
  output logic [SLOTS*IDX_W-1:0] slot_idx,
  output logic                   busy,
  output logic                   overflow,
`ifdef OBJ_SCHED_STATS_EN
  input  logic                   frame_start,
  output logic [7:0]             drop_count,
`endif
  output logic                   late_err
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_READY} state_t;

  state_t           state;
  logic [9:0]       line_y_q;
  logic [SLOTS-1:0] sh_valid;
  logic [IDX_W-1:0] sh_idx [SLOTS];
  logic [3:0]       sh_r   [SLOTS];
  logic             sh_ovf;

  logic [SLOTS-1:0] n_valid;
  logic [IDX_W-1:0] n_idx [SLOTS];
  logic [3:0]       n_r   [SLOTS];
  int               ins_pos;

  logic [10:0] obj_h;
  logic [10:0] obj_end;
  logic [10:0] row;
  logic        is_cand;
  logic        table_full;
  logic        cand_drop;
  logic        scan_last;

  // 11-bit compare so an object near the bottom does not wrap to the top rows
  assign obj_h      = 11'd64 - {6'd0, obj_r, 1'b0};
  assign obj_end    = {1'b0, obj_y_pos} + obj_h;
  assign row        = {1'b0, line_y_q};
  assign is_cand    = obj_active && (obj_quadrant == 2'(QUADRANT)) &&
                      ({1'b0, obj_y_pos} <= row) && (row < obj_end);
  assign table_full = sh_valid[SLOTS-1];
  assign cand_drop  = is_cand && table_full;
  assign scan_last  = (obj_idx == IDX_W'(OBJ_LIMIT - 1));

  // Sorted insertion. Valid slots are contiguous from slot 0 and sorted, and
  // the new entry has the largest idx seen so far, so it goes after every slot
  // with r <= its own r. A position of SLOTS means the candidate is dropped;
  // otherwise the tail shifts down and the last slot falls off when full.
  always_comb begin
    n_valid = sh_valid;
    n_idx   = sh_idx;
    n_r     = sh_r;
    ins_pos = 0;
    for (int k = 0; k < SLOTS; k++) begin
      if (sh_valid[k] && (sh_r[k] <= obj_r)) ins_pos = k + 1;
    end
    if (is_cand && (ins_pos < SLOTS)) begin
      for (int k = 1; k < SLOTS; k++) begin
        if (k > ins_pos) begin
          n_valid[k] = sh_valid[k-1];
          n_idx[k]   = sh_idx[k-1];
          n_r[k]     = sh_r[k-1];
        end
      end
      for (int k = 0; k < SLOTS; k++) begin
        if (k == ins_pos) begin
          n_valid[k] = 1'b1;
          n_idx[k]   = obj_idx;
          n_r[k]     = obj_r;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      line_y_q   <= '0;
      obj_idx    <= '0;
      sh_valid   <= '0;
      sh_ovf     <= 1'b0;
      slot_valid <= '0;
      slot_idx   <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      late_err   <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        sh_idx[k] <= '0;
        sh_r[k]   <= '0;
      end
    end else begin
      case (state)
        S_SCAN: begin
          sh_valid <= n_valid;
          sh_idx   <= n_idx;
          sh_r     <= n_r;
          if (cand_drop) sh_ovf <= 1'b1;
          if (scan_last) begin
            state   <= S_READY;
            busy    <= 1'b0;
            obj_idx <= '0;
          end else begin
            obj_idx <= obj_idx + 1'b1;
          end
          // Early commit: blank the line rather than show a partial table
          if (line_commit) begin
            slot_valid <= '0;
            late_err   <= 1'b1;
          end
        end
        S_READY: begin
          if (line_commit) begin
            slot_valid <= sh_valid;
            overflow   <= sh_ovf;
            for (int k = 0; k < SLOTS; k++) slot_idx[k*IDX_W +: IDX_W] <= sh_idx[k];
            state <= S_IDLE;
          end
        end
        default: ;
      endcase

      // A new scan starts from any state; placed last so it overrides the
      // scan progression above, while a same-cycle READY commit still
      // publishes the old shadow table first.
      if (line_start) begin
        if (state == S_SCAN) late_err <= 1'b1;
        line_y_q <= line_y;
        sh_valid <= '0;
        sh_ovf   <= 1'b0;
        obj_idx  <= '0;
        state    <= S_SCAN;
        busy     <= 1'b1;
        for (int k = 0; k < SLOTS; k++) begin
          sh_idx[k] <= '0;
          sh_r[k]   <= '0;
        end
      end
    end
  end

`ifdef OBJ_SCHED_STATS_EN
  // A drop only counts when the entry is really evaluated (not on an abort cycle)
  logic drop_event;
  assign drop_event = (state == S_SCAN) && !line_start && cand_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
    end else if (frame_start) begin
      drop_count <= {7'd0, drop_event};
    end else if (drop_event && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/obj_line_scheduler.md
Name: obj_line_scheduler

Overview:
- Per-scanline object scheduler for the quadrant renderer.
- During horizontal blanking it scans the alien object table one entry per cycle and keeps the objects that cover the next scanline in this QUADRANT.
- It sorts the kept objects nearest-first into a shadow slot table, then swaps that table into the active table on a commit pulse.
- The pixel path therefore does at most SLOTS sprite-ROM lookups per line, in priority order, with no per-pixel OBJ_LIMIT-wide search.

Parameters:
OBJ_LIMIT, 16, number of object table entries scanned per line
SLOTS, 4, maximum objects scheduled per scanline
QUADRANT, 0, quadrant this instance serves
IDX_W, 4, width of object index; must satisfy 2**IDX_W >= OBJ_LIMIT

Ports:
clk  input  1  pixel-domain clock
rst  input  1  asynchronous reset, active-low
line_start  input  1  single-cycle pulse; starts a scan for line_y
line_y  input  10  scanline to schedule, 0..479
line_commit  input  1  single-cycle pulse at start of active video; publishes the shadow table
obj_idx  output  IDX_W  object table read index; table answers combinationally in the same cycle
obj_active  input  1  entry active
obj_quadrant  input  2  entry quadrant
obj_r  input  4  entry distance, 0 = nearest
obj_y_pos  input  10  entry top row
slot_valid  output  SLOTS  active-table slot occupied; slot 0 = highest priority
slot_idx  output  SLOTS*IDX_W  active-table object index per slot, slot k at [k*IDX_W +: IDX_W]
busy  output  1  scan in progress
overflow  output  1  more than SLOTS candidates on the last committed line
late_err  output  1  sticky; a scan was aborted or a commit arrived before the scan finished

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; obj_idx=0; slot_valid=0; slot_idx=0; shadow table empty; busy=0; overflow=0; late_err=0.
- FSM states: IDLE, SCAN, READY.
- IDLE: on line_start, latch line_y, clear the shadow table and the shadow overflow flag, set obj_idx=0, go to SCAN.
- SCAN, each cycle:
  - Sprite height h = 64 - 2*obj_r, computed in 11 bits.
  - Entry is a candidate when obj_active=1, obj_quadrant==QUADRANT and obj_y_pos <= line_y < obj_y_pos + h. Compare in 11 bits with no wrap; an object at y_pos=470 with r=0 covers rows 470..533 and therefore covers only 470..479 in practice.
  - Candidates are inserted into the shadow table in order of key {r, idx}, ascending. Entries arrive in idx order, so on an equal r the new entry goes after the existing ones.
  - Table full: if the candidate key is lower than slot SLOTS-1, the last slot is evicted and the candidate inserted; otherwise the candidate is dropped. Either case sets shadow overflow.
  - obj_idx increments each cycle. After index OBJ_LIMIT-1 is evaluated, go to READY.
  - Latency: exactly OBJ_LIMIT cycles from the line_start cycle to READY.
- READY: hold the shadow table.
- line_commit in READY: next cycle the active table and overflow take the shadow values; go to IDLE.
- line_commit in SCAN:
  - slot_valid is cleared and late_err is set.
  - The scan continues; its result is published on the next commit.
- line_commit in IDLE: no change.
- line_start in SCAN: abort, restart from obj_idx=0 with the new line_y, set late_err.
- line_start in READY: discard the shadow table, restart the scan. late_err is not set (an uncommitted line is legal).
- line_start and line_commit in the same cycle: commit takes effect first (READY: publish), then the new scan starts.
- busy=1 exactly while in SCAN.
- late_err clears only on reset.

Optional Feature:
- Macro OBJ_SCHED_STATS_EN. When defined, adds two ports:
  - frame_start input 1
  - drop_count output 8: saturating count of candidates dropped or evicted since the last frame_start.
- frame_start clears drop_count to 0 on the following cycle; if a drop happens in that same cycle, the result is 1.
- drop_count saturates at 255.
- When the macro is undefined, neither port exists and the behaviour is otherwise identical.

Test Plan:
- Single candidate: entry 3 active, quadrant 0, r=2, y_pos=100; line_start with line_y=130; line_commit after 16 cycles -> slot_valid=0001, slot0 idx=3, overflow=0.
- Sort order: entries 1 (r=5), 2 (r=1), 7 (r=1), 9 (r=0), all covering line_y -> slots {9,2,7,1}, all valid, overflow=0.
- Overflow and eviction: six candidates with r = 8,7,6,5,4,3 at idx 0..5 -> slots {5,4,3,2}, overflow=1; with the stats macro defined, drop_count=2.
- Boundary rows: r=15 (h=34), y_pos=200 -> line_y=233 is scheduled, line_y=234 and line_y=199 are not. An entry in quadrant 1 is never scheduled.
- Late commit: line_commit 5 cycles after line_start -> slot_valid=0 and late_err=1. A later commit once READY publishes the correct table.
- Reset mid-scan: drop rst for one cycle at cycle 8 of SCAN -> all outputs return to reset values immediately, and the FSM ignores line_commit until the next line_start.
